// File: rtl/display_pkg.sv
// Shared types, constants and select-mask helper for the multiplexed display scan path.
package display_pkg;

    localparam int WORD_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_DWELL,
        ST_BLANK
    } scan_state_t;

    localparam logic [WORD_W-1:0] BLANK_WORD = 16'hFF00;
    localparam logic [7:0]        SEL_IDLE   = 8'hFF;

    // Active-low digit select: only bit idx is driven low.
    function automatic logic [7:0] sel_mask(input logic [2:0] idx);
        return SEL_IDLE & ~(8'b1 << idx);
    endfunction

endpackage

// File: rtl/display_scan_scheduler_if.sv
// Word handshake between the scan scheduler (master) and the 74HC595 serializer (slave).
interface display_scan_scheduler_if;
    import display_pkg::*;

    logic [WORD_W-1:0] word_out;
    logic              word_valid;
    logic              word_ready;

    modport master (output word_out, output word_valid, input word_ready);
    modport slave  (input word_out, input word_valid, output word_ready);

endinterface

// File: rtl/dwell_timer.sv
// Loadable down-counter that saturates at zero; expired while the count is zero.
module dwell_timer #(
    parameter int WIDTH = 16
) (
    input  logic             s_clk,
    input  logic             s_reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_value,
    input  logic             i_count,
    output logic             o_expired
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge s_clk or posedge s_reset) begin
        if (s_reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (i_count && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_expired = (r_count == '0);

endmodule

// File: rtl/display_scan_scheduler.sv
// Digit-scan sequencer: snapshots a frame at digit 0 and offers one {sel, seg} word
// per digit to the serializer, spacing successive words by a fixed dwell.
module display_scan_scheduler
    import display_pkg::*;
#(
    parameter int DIGITS       = 6,
    parameter int DWELL_CYCLES = 50000
) (
    input  logic                    s_clk,
    input  logic                    s_reset,
    input  logic                    enable,
    input  logic [8*DIGITS-1:0]     data_in,
    display_scan_scheduler_if.master scan,
    output logic                    frame_start,
    output logic [2:0]              digit_idx
);

    localparam int              CNT_W      = $clog2(DWELL_CYCLES);
    // SEND and LOAD each take one cycle of the digit period; DWELL covers the rest.
    localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 3);
    localparam logic [2:0]       LAST_IDX   = 3'(DIGITS - 1);

    generate
        if (DWELL_CYCLES < 3) begin : g_bad_dwell
            $error("display_scan_scheduler: DWELL_CYCLES must be at least 3");
        end
        if ((DIGITS < 1) || (DIGITS > 8)) begin : g_bad_digits
            $error("display_scan_scheduler: DIGITS must be within 1..8");
        end
    endgenerate

    scan_state_t          r_state, w_state_next;
    logic [WORD_W-1:0]    r_word, w_word_next;
    logic                 r_valid, w_valid_next;
    logic                 r_frame_start, w_frame_start_next;
    logic [2:0]           r_idx, w_idx_next;
    logic [8*DIGITS-1:0]  r_frame, w_frame_next;
    logic                 w_timer_load, w_timer_count, w_expired, w_xfer;
    logic [8*DIGITS-1:0]  w_src;
    logic [7:0]           w_src_byte [DIGITS];
    logic [7:0]           w_seg;

    dwell_timer #(.WIDTH(CNT_W)) u_dwell (
        .s_clk     (s_clk),
        .s_reset   (s_reset),
        .i_load    (w_timer_load),
        .i_value   (DWELL_LOAD),
        .i_count   (w_timer_count),
        .o_expired (w_expired)
    );

    // Digit 0 reads live data so its word matches the snapshot taken on the same edge.
    assign w_src = (r_idx == 3'd0) ? data_in : r_frame;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_byte
            assign w_src_byte[gi] = w_src[8*gi +: 8];
        end
    endgenerate

    assign w_seg  = w_src_byte[r_idx];
    assign w_xfer = r_valid && scan.word_ready;

    always_comb begin
        w_state_next       = r_state;
        w_word_next        = r_word;
        w_valid_next       = r_valid;
        w_frame_start_next = 1'b0;
        w_idx_next         = r_idx;
        w_frame_next       = r_frame;
        w_timer_load       = 1'b0;
        w_timer_count      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_word_next  = BLANK_WORD;
                w_valid_next = 1'b0;
                if (enable) begin
                    w_state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (r_idx == 3'd0) begin
                    w_frame_next       = data_in;
                    w_frame_start_next = 1'b1;
                end
                w_word_next  = {sel_mask(r_idx), w_seg};
                w_valid_next = 1'b1;
                w_state_next = ST_SEND;
            end
            ST_SEND: begin
                if (w_xfer) begin
                    w_valid_next = 1'b0;
                    w_timer_load = 1'b1;
                    w_state_next = ST_DWELL;
                end
            end
            ST_DWELL: begin
                w_timer_count = 1'b1;
                if (w_expired) begin
                    w_idx_next = (r_idx == LAST_IDX) ? 3'd0 : r_idx + 3'd1;
                    if (enable) begin
                        w_state_next = ST_LOAD;
                    end else begin
                        w_word_next  = BLANK_WORD;
                        w_valid_next = 1'b1;
                        w_state_next = ST_BLANK;
                    end
                end
            end
            ST_BLANK: begin
                if (w_xfer) begin
                    w_valid_next = 1'b0;
                    w_idx_next   = 3'd0;
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge s_clk or posedge s_reset) begin
        if (s_reset) begin
            r_state       <= ST_IDLE;
            r_word        <= BLANK_WORD;
            r_valid       <= 1'b0;
            r_frame_start <= 1'b0;
            r_idx         <= 3'd0;
            r_frame       <= '0;
        end else begin
            r_state       <= w_state_next;
            r_word        <= w_word_next;
            r_valid       <= w_valid_next;
            r_frame_start <= w_frame_start_next;
            r_idx         <= w_idx_next;
            r_frame       <= w_frame_next;
        end
    end

    assign scan.word_out   = r_word;
    assign scan.word_valid = r_valid;
    assign frame_start     = r_frame_start;
    assign digit_idx       = r_idx;

endmodule

// File: tb/tb_display_scan_scheduler.sv
// Self-checking bench for display_scan_scheduler with DIGITS=6, DWELL_CYCLES=8.
module tb_display_scan_scheduler;

    localparam int DIGITS = 6;
    localparam int DWELL  = 8;

    logic        s_clk = 1'b0;
    logic        s_reset;
    logic        enable;
    logic [47:0] data_in;
    logic        frame_start;
    logic [2:0]  digit_idx;

    display_scan_scheduler_if bus();

    display_scan_scheduler #(.DIGITS(DIGITS), .DWELL_CYCLES(DWELL)) dut (
        .s_clk       (s_clk),
        .s_reset     (s_reset),
        .enable      (enable),
        .data_in     (data_in),
        .scan        (bus),
        .frame_start (frame_start),
        .digit_idx   (digit_idx)
    );

    always #5 s_clk = ~s_clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          exp_digit = 0;
    int          last_xfer_cyc = 0;
    logic [47:0] model_frame = '0;

    // Reference word: one low select bit for digit k, segment byte straight from the frame.
    function automatic logic [15:0] exp_word(input logic [47:0] frame, input int k);
        logic [7:0] sel;
        sel    = 8'hFF;
        sel[k] = 1'b0;
        return {sel, frame[8*k +: 8]};
    endfunction

    task automatic tick();
        @(posedge s_clk);
        #1;
        cyc++;
    endtask

    task automatic wait_valid(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (bus.word_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (bus.word_valid === 1'b1) ok = 1'b1;
    endtask

    // Waits for the next offered digit word and advances the model frame at digit 0.
    task automatic next_offer(output bit ok, output int gap, output logic [15:0] ew, output int ek);
        wait_valid(24, ok);
        gap = cyc - last_xfer_cyc;
        if (exp_digit == 0) model_frame = data_in;
        ew = exp_word(model_frame, exp_digit);
        ek = exp_digit;
    endtask

    task automatic transfer();
        bus.word_ready = 1'b1;
        last_xfer_cyc  = cyc;
        $display("xfer cycle=%0d word=%h digit=%0d", cyc, bus.word_out, exp_digit);
        tick();
        exp_digit = (exp_digit + 1) % DIGITS;
    endtask

    task automatic test_reset();
        s_reset = 1'b1; enable = 1'b0; bus.word_ready = 1'b0; data_in = '0;
        tick(); tick();
        n_checks++; if (bus.word_out !== 16'hFF00) begin n_fail++; $display("FAIL reset_word: got %h expected ff00", bus.word_out); end
        n_checks++; if (bus.word_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", bus.word_valid); end
        n_checks++; if (digit_idx !== 3'd0) begin n_fail++; $display("FAIL reset_idx: got %0d expected 0", digit_idx); end
        n_checks++; if (frame_start !== 1'b0) begin n_fail++; $display("FAIL reset_fs: got %b expected 0", frame_start); end
        s_reset = 1'b0;
        repeat (4) tick();
        n_checks++; if (bus.word_valid !== 1'b0) begin n_fail++; $display("FAIL idle_valid: got %b expected 0", bus.word_valid); end
    endtask

    task automatic test_basic_frame();
        logic [15:0] tbl [7] = '{16'hFE01, 16'hFD02, 16'hFB03, 16'hF704, 16'hEF05, 16'hDF06, 16'hFE01};
        bit ok; int gap; logic [15:0] ew; int ek; int start;
        data_in = 48'h060504030201; bus.word_ready = 1'b1; enable = 1'b1;
        start = cyc;
        for (int w = 0; w < 7; w++) begin
            next_offer(ok, gap, ew, ek);
            n_checks++; if (!ok) begin n_fail++; $display("FAIL basic_timeout: word %0d got no valid expected valid", w); end
            if (w == 0) begin
                n_checks++; if (cyc - start != 2) begin n_fail++; $display("FAIL basic_latency: got %0d expected 2", cyc - start); end
            end else begin
                n_checks++; if (gap != DWELL) begin n_fail++; $display("FAIL basic_gap: got %0d expected %0d", gap, DWELL); end
            end
            n_checks++; if (bus.word_out !== tbl[w] || ew !== tbl[w]) begin n_fail++; $display("FAIL basic_word: got %h expected %h", bus.word_out, tbl[w]); end
            n_checks++; if (digit_idx !== 3'(ek)) begin n_fail++; $display("FAIL basic_idx: got %0d expected %0d", digit_idx, ek); end
            n_checks++; if (frame_start !== (ek == 0)) begin n_fail++; $display("FAIL basic_fs: got %b expected %b", frame_start, ek == 0); end
            transfer();
            n_checks++; if (bus.word_valid !== 1'b0 || frame_start !== 1'b0) begin n_fail++; $display("FAIL basic_drop: got valid=%b fs=%b expected 0 0", bus.word_valid, frame_start); end
        end
    endtask

    task automatic test_backpressure();
        bit ok; int gap; logic [15:0] ew; int ek;
        next_offer(ok, gap, ew, ek);
        n_checks++; if (!ok || bus.word_out !== 16'hFD02) begin n_fail++; $display("FAIL bp_pre_word: got %h expected fd02", bus.word_out); end
        transfer();
        next_offer(ok, gap, ew, ek);
        bus.word_ready = 1'b0;
        n_checks++; if (!ok || bus.word_out !== 16'hFB03) begin n_fail++; $display("FAIL bp_word: got %h expected fb03", bus.word_out); end
        for (int s = 0; s < 5; s++) begin
            tick();
            n_checks++;
            if (bus.word_valid !== 1'b1 || bus.word_out !== 16'hFB03 || digit_idx !== 3'd2) begin
                n_fail++; $display("FAIL bp_hold: got valid=%b word=%h idx=%0d expected 1 fb03 2", bus.word_valid, bus.word_out, digit_idx);
            end
        end
        transfer();
        n_checks++; if (bus.word_valid !== 1'b0) begin n_fail++; $display("FAIL bp_xfer: got valid=%b expected 0", bus.word_valid); end
    endtask

    task automatic test_data_change();
        logic [15:0] tbl [4] = '{16'hF704, 16'hEF05, 16'hDF06, 16'hFE07};
        bit ok; int gap; logic [15:0] ew; int ek;
        for (int w = 0; w < 4; w++) begin
            next_offer(ok, gap, ew, ek);
            n_checks++; if (!ok || gap != DWELL) begin n_fail++; $display("FAIL chg_gap: got %0d expected %0d", gap, DWELL); end
            n_checks++; if (bus.word_out !== tbl[w] || ew !== tbl[w]) begin n_fail++; $display("FAIL chg_word: got %h expected %h", bus.word_out, tbl[w]); end
            n_checks++; if (frame_start !== (w == 3)) begin n_fail++; $display("FAIL chg_fs: got %b expected %b", frame_start, w == 3); end
            if (w == 0) data_in = 48'h0C0B0A090807;
            transfer();
        end
    endtask

    task automatic test_enable_drop();
        bit ok; int gap; logic [15:0] ew; int ek; int start;
        next_offer(ok, gap, ew, ek);
        n_checks++; if (!ok || bus.word_out !== 16'hFD08) begin n_fail++; $display("FAIL en_word: got %h expected fd08", bus.word_out); end
        transfer();
        enable = 1'b0;
        wait_valid(24, ok);
        n_checks++; if (!ok || bus.word_out !== 16'hFF00) begin n_fail++; $display("FAIL en_blank: got %h expected ff00", bus.word_out); end
        $display("xfer cycle=%0d word=%h blank", cyc, bus.word_out);
        tick();
        n_checks++; if (bus.word_valid !== 1'b0 || digit_idx !== 3'd0) begin n_fail++; $display("FAIL en_idle: got valid=%b idx=%0d expected 0 0", bus.word_valid, digit_idx); end
        repeat (5) tick();
        n_checks++; if (bus.word_valid !== 1'b0 || bus.word_out !== 16'hFF00) begin n_fail++; $display("FAIL en_stay_idle: got valid=%b word=%h expected 0 ff00", bus.word_valid, bus.word_out); end
        exp_digit = 0;
        enable = 1'b1;
        start = cyc;
        next_offer(ok, gap, ew, ek);
        n_checks++; if (!ok || cyc - start != 2) begin n_fail++; $display("FAIL en_restart_latency: got %0d expected 2", cyc - start); end
        n_checks++; if (bus.word_out !== 16'hFE07 || frame_start !== 1'b1) begin n_fail++; $display("FAIL en_restart: got %h fs=%b expected fe07 1", bus.word_out, frame_start); end
        transfer();
    endtask

    task automatic test_random();
        bit ok; int gap; logic [15:0] ew; int ek; int stall;
        for (int w = 0; w < 30; w++) begin
            next_offer(ok, gap, ew, ek);
            n_checks++; if (!ok || gap != DWELL) begin n_fail++; $display("FAIL rnd_gap: got %0d expected %0d", gap, DWELL); end
            n_checks++; if (bus.word_out !== ew || digit_idx !== 3'(ek)) begin n_fail++; $display("FAIL rnd_word: got %h idx=%0d expected %h idx=%0d", bus.word_out, digit_idx, ew, ek); end
            n_checks++; if (frame_start !== (ek == 0)) begin n_fail++; $display("FAIL rnd_fs: got %b expected %b", frame_start, ek == 0); end
            stall = $urandom_range(0, 3);
            bus.word_ready = 1'b0;
            for (int s = 0; s < stall; s++) begin
                tick();
                n_checks++; if (bus.word_valid !== 1'b1 || bus.word_out !== ew) begin n_fail++; $display("FAIL rnd_hold: got valid=%b word=%h expected 1 %h", bus.word_valid, bus.word_out, ew); end
            end
            if (ek != 0 && $urandom_range(0, 1) == 1) data_in = 48'({$urandom(), $urandom()});
            transfer();
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        wait_valid(24, ok);
        bus.word_ready = 1'b0;
        tick(); tick();
        #2 s_reset = 1'b1;
        #1;
        n_checks++; if (bus.word_valid !== 1'b0 || bus.word_out !== 16'hFF00) begin n_fail++; $display("FAIL rst_async: got valid=%b word=%h expected 0 ff00", bus.word_valid, bus.word_out); end
        n_checks++; if (digit_idx !== 3'd0 || frame_start !== 1'b0) begin n_fail++; $display("FAIL rst_async_idx: got idx=%0d fs=%b expected 0 0", digit_idx, frame_start); end
        tick(); tick();
        n_checks++; if (bus.word_valid !== 1'b0 || bus.word_out !== 16'hFF00 || digit_idx !== 3'd0) begin n_fail++; $display("FAIL rst_hold: got valid=%b word=%h idx=%0d expected 0 ff00 0", bus.word_valid, bus.word_out, digit_idx); end
        s_reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_backpressure();
        test_data_change();
        test_enable_drop();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000ns");
        $fatal(1, "watchdog expired");
    end

endmodule
